fetch_stage: RTL

Instruction-fetch stage of the 5-stage RISC pipeline, directly upstream of the decode stage. Owns the 32-bit PC and the IF/ID pipeline register. Loads the reset vector, assembles two-word (immediate) instructions and applies redirects from branches and popped return addresses. Injects the interrupt pseudo-instruction and hands decode one complete instruction per valid cycle.

---
 rtl/pipeline_pkg.sv | 37 +++
 rtl/fetch_stage_if.sv | 37 +++
 rtl/fetch_stage_pc_reg.sv | 48 ++++
 rtl/fetch_stage.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// The INT_HI/INT_LO states only exist when FETCH_INT_EN is defined.
package pipeline_pkg;

  localparam logic [15:0] NOP_WORD        = 16'h0000;
  localparam logic [4:0]  INT_OPC         = 5'b11111;
  localparam logic [2:0]  TWO_WORD_PREFIX = 3'b110;
  localparam int unsigned RESET_VEC_ADDR  = 0;
  localparam int unsigned INT_VEC_ADDR    = 2;

  typedef enum logic [2:0] {
    RST_HI = 3'd0,
    RST_LO = 3'd1,
    RUN    = 3'd2,
`ifdef FETCH_INT_EN
    IMM    = 3'd3,
    INT_HI = 3'd4,
    INT_LO = 3'd5
`else
    IMM    = 3'd3
`endif
  } state_t;

  typedef enum logic [2:0] {
    PC_HOLD    = 3'd0,
    PC_INC     = 3'd1,
    PC_LOAD_HI = 3'd2,
    PC_LOAD_LO = 3'd3,
    PC_JMP     = 3'd4,
    PC_POP     = 3'd5
  } pc_op_t;

  function automatic logic is_two_word(input logic [15:0] word);
    return word[15:13] == TWO_WORD_PREFIX;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction memory, decode/memory-stage controls and the IF/ID register.
// master = fetch stage, slave = surrounding pipeline; state is the FSM state for observation.
interface fetch_stage_if #(
  parameter int WIDTH = 16,
  parameter int PC_W  = 32
);
  import pipeline_pkg::*;

  logic [PC_W-1:0]  imem_addr;
  logic [WIDTH-1:0] imem_data;
  logic             stall;
  logic             branch_taken;
  logic [PC_W-1:0]  pc_jmp;
  logic             pop_pc1;
  logic             pop_pc2;
  logic [WIDTH-1:0] pop_data;
  logic             interrupt;
  logic             int_ack;
  logic [WIDTH-1:0] instruction;
  logic [WIDTH-1:0] imm;
  logic [PC_W-1:0]  pc_next;
  logic             valid;
  state_t           state;

  // No handshake back-pressure: valid marks a real instruction in IF/ID and
  // stall freezes the stage; there is no ready signal in either direction.
  modport master (
    output imem_addr, int_ack, instruction, imm, pc_next, valid, state,
    input  imem_data, stall, branch_taken, pc_jmp, pop_pc1, pop_pc2, pop_data, interrupt
  );

  modport slave (
    input  imem_addr, int_ack, instruction, imm, pc_next, valid, state,
    output imem_data, stall, branch_taken, pc_jmp, pop_pc1, pop_pc2, pop_data, interrupt
  );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter with next-PC mux, wrapping increment and return-address high-half staging.
// Assumes PC_W == 2*WIDTH so a PC is exactly two instruction words.
module pc_reg
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PC_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  pc_op_t           pc_op,
  input  logic [WIDTH-1:0] load_word,
  input  logic [PC_W-1:0]  jmp_target,
  input  logic             pop_pc1,
  input  logic [WIDTH-1:0] pop_data,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus1
);

  logic [WIDTH-1:0] hi_q;
  logic [PC_W-1:0]  pc_d;

  assign pc_plus1 = pc + PC_W'(1);

  always_comb begin
    pc_d = pc;
    case (pc_op)
      PC_INC:     pc_d = pc_plus1;
      PC_LOAD_HI: pc_d = {load_word, pc[PC_W-WIDTH-1:0]};
      PC_LOAD_LO: pc_d = {pc[PC_W-1:WIDTH], load_word};
      PC_JMP:     pc_d = jmp_target;
      PC_POP:     pc_d = {hi_q, pop_data};
      default:    pc_d = pc;
    endcase
  end

  // hi_q captures the return-PC high half regardless of stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc   <= '0;
      hi_q <= '0;
    end else begin
      pc <= pc_d;
      if (pop_pc1) hi_q <= pop_data;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: reset-vector load, two-word assembly, redirects and the IF/ID register.
// Define FETCH_INT_EN to build the interrupt pseudo-instruction path (INT_HI/INT_LO, int_ack).
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int PC_W  = 32
) (
  input logic         clk,
  input logic         rst,
  fetch_stage_if.master bus
);

  localparam logic [WIDTH-1:0] INT_WORD = {INT_OPC, {(WIDTH-5){1'b0}}};

  state_t           state_q, state_d;
  pc_op_t           pc_op;
  logic [PC_W-1:0]  pc, pc_plus1;
  logic [WIDTH-1:0] first_q, first_d;
  logic [WIDTH-1:0] ins_q, ins_d, imm_q, imm_d;
  logic [PC_W-1:0]  pcn_q, pcn_d;
  logic             valid_q, valid_d, ack_q, ack_d;
  logic             bubble;

  pc_reg #(.WIDTH(WIDTH), .PC_W(PC_W)) u_pc_reg (
    .clk        (clk),
    .rst        (rst),
    .pc_op      (pc_op),
    .load_word  (bus.imem_data),
    .jmp_target (bus.pc_jmp),
    .pop_pc1    (bus.pop_pc1),
    .pop_data   (bus.pop_data),
    .pc         (pc),
    .pc_plus1   (pc_plus1)
  );

  always_comb begin
    bus.imem_addr = pc;
    case (state_q)
      RST_HI: bus.imem_addr = PC_W'(RESET_VEC_ADDR);
      RST_LO: bus.imem_addr = PC_W'(RESET_VEC_ADDR + 1);
`ifdef FETCH_INT_EN
      INT_HI: bus.imem_addr = PC_W'(INT_VEC_ADDR);
      INT_LO: bus.imem_addr = PC_W'(INT_VEC_ADDR + 1);
`endif
      default: bus.imem_addr = pc;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_op   = PC_HOLD;
    first_d = first_q;
    ins_d   = ins_q;
    imm_d   = imm_q;
    pcn_d   = pcn_q;
    valid_d = valid_q;
    ack_d   = ack_q;
    bubble  = 1'b0;
    if (state_q == RST_HI || state_q == RST_LO) begin
      pc_op   = (state_q == RST_HI) ? PC_LOAD_HI : PC_LOAD_LO;
      state_d = (state_q == RST_HI) ? RST_LO : RUN;
      bubble  = 1'b1;
    end else if (bus.pop_pc2 || bus.branch_taken) begin
      // A redirect beats stall and abandons any half-assembled instruction.
      pc_op   = bus.pop_pc2 ? PC_POP : PC_JMP;
      state_d = RUN;
      bubble  = 1'b1;
    end else if (!bus.stall) begin
      case (state_q)
        RUN: begin
`ifdef FETCH_INT_EN
          if (bus.interrupt) begin
            ins_d   = INT_WORD;
            imm_d   = '0;
            pcn_d   = pc;
            valid_d = 1'b1;
            ack_d   = 1'b1;
            state_d = INT_HI;
          end else
`endif
          if (is_two_word(bus.imem_data)) begin
            first_d = bus.imem_data;
            pc_op   = PC_INC;
            state_d = IMM;
            bubble  = 1'b1;
          end else begin
            ins_d   = bus.imem_data;
            imm_d   = '0;
            pcn_d   = pc_plus1;
            valid_d = 1'b1;
            ack_d   = 1'b0;
            pc_op   = PC_INC;
          end
        end
        IMM: begin
          ins_d   = first_q;
          imm_d   = bus.imem_data;
          pcn_d   = pc_plus1;
          valid_d = 1'b1;
          ack_d   = 1'b0;
          pc_op   = PC_INC;
          state_d = RUN;
        end
`ifdef FETCH_INT_EN
        INT_HI: begin
          pc_op   = PC_LOAD_HI;
          state_d = INT_LO;
          bubble  = 1'b1;
        end
        INT_LO: begin
          pc_op   = PC_LOAD_LO;
          state_d = RUN;
          bubble  = 1'b1;
        end
`endif
        default: state_d = state_q;
      endcase
    end
    if (bubble) begin
      ins_d   = NOP_WORD;
      imm_d   = '0;
      pcn_d   = '0;
      valid_d = 1'b0;
      ack_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_HI;
      first_q <= '0;
      ins_q   <= '0;
      imm_q   <= '0;
      pcn_q   <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      ins_q   <= ins_d;
      imm_q   <= imm_d;
      pcn_q   <= pcn_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
    end
  end

`ifndef FETCH_INT_EN
  logic unused_interrupt;
  assign unused_interrupt = bus.interrupt;
`endif

  assign bus.instruction = ins_q;
  assign bus.imm         = imm_q;
  assign bus.pc_next     = pcn_q;
  assign bus.valid       = valid_q;
  assign bus.int_ack     = ack_q;
  assign bus.state       = state_q;

endmodule
